// File: rtl/riscv_pkg.sv
// riscv_pkg: RISC-V constants shared by fetch and control, plus fetch FSM states
package riscv_pkg;
  localparam int XLEN_DEFAULT = 32;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  typedef logic [1:0] state_t;
  localparam state_t S_BOOT = 2'd0;
  localparam state_t S_REQ  = 2'd1;
  localparam state_t S_KILL = 2'd2;
  localparam state_t S_HOLD = 2'd3;
endpackage

// File: rtl/instr_fetch_if.sv
// instr_fetch_if: instruction memory request/valid bus
interface instr_fetch_if #(parameter int XLEN = riscv_pkg::XLEN_DEFAULT);
  logic            req;
  logic [XLEN-1:0] addr;
  logic            valid;
  logic [31:0]     rdata;
  modport master(output req, addr, input valid, rdata);
  modport slave(input req, addr, output valid, rdata);
endinterface

// File: rtl/if_id_reg.sv
// if_id_reg: IF/ID pipeline register with load, stall hold and redirect flush
module if_id_reg import riscv_pkg::*; #(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load_i,
  input  logic            stall_i,
  input  logic            flush_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic [31:0]     instr_i,
  output logic            valid_o,
  output logic [XLEN-1:0] pc_o,
  output logic [31:0]     instr_o
);
  logic            valid_q;
  logic [XLEN-1:0] pc_q;
  logic [31:0]     instr_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n || flush_i) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
      instr_q <= NOP;
    end else if (!stall_i) begin
      valid_q <= load_i;
      if (load_i) begin
        pc_q    <= pc_i;
        instr_q <= instr_i;
      end
    end
  assign valid_o = valid_q;
  assign pc_o    = pc_q;
  assign instr_o = instr_q;
endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: PC, fetch FSM and one-entry hold buffer feeding the IF/ID register
module instr_fetch import riscv_pkg::*; #(
  parameter int              XLEN     = XLEN_DEFAULT,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  instr_fetch_if.master   imem,
  output logic            if_id_valid,
  output logic [XLEN-1:0] if_id_pc,
  output logic [31:0]     if_id_instr,
  output logic [6:0]      opcode,
  output logic [2:0]      funct3,
  output logic [6:0]      funct7,
  output logic [31:0]     fetch_count
);
  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d, addr_q, addr_d, buf_pc_q, buf_pc_d, ld_pc, tgt;
  logic [31:0]     buf_instr_q, buf_instr_d, ld_instr, fetch_count_q, fetch_count_d;
  logic            load;
  assign tgt       = redirect_pc & ~XLEN'(3);
  assign imem.req  = (state_q == S_REQ) || (state_q == S_KILL);
  assign imem.addr = addr_q;
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    buf_pc_d    = buf_pc_q;
    buf_instr_d = buf_instr_q;
    load        = 1'b0;
    ld_pc       = pc_q;
    ld_instr    = imem.rdata;
    if (redirect) begin
      pc_d    = tgt;
      state_d = (imem.req && !imem.valid) ? S_KILL : S_REQ;
    end else if (state_q == S_BOOT) begin
      state_d = S_REQ;
    end else if (state_q == S_KILL) begin
      state_d = imem.valid ? S_REQ : S_KILL;
    end else if (state_q == S_REQ && imem.valid) begin
      pc_d        = pc_q + XLEN'(4);
      load        = !stall;
      state_d     = stall ? S_HOLD : S_REQ;
      buf_pc_d    = pc_q;
      buf_instr_d = imem.rdata;
    end else if (state_q == S_HOLD && !stall) begin
      load     = 1'b1;
      ld_pc    = buf_pc_q;
      ld_instr = buf_instr_q;
      state_d  = S_REQ;
    end
    fetch_count_d = fetch_count_q + {31'd0, load};
    // the killed request keeps its address on the bus until memory answers it
    addr_d = (state_d == S_KILL) ? addr_q : pc_d;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q       <= S_BOOT;
      pc_q          <= RESET_PC;
      addr_q        <= RESET_PC;
      buf_pc_q      <= '0;
      buf_instr_q   <= NOP;
      fetch_count_q <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      addr_q        <= addr_d;
      buf_pc_q      <= buf_pc_d;
      buf_instr_q   <= buf_instr_d;
      fetch_count_q <= fetch_count_d;
    end
  if_id_reg #(.XLEN(XLEN)) u_if_id (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (load),
    .stall_i (stall),
    .flush_i (redirect),
    .pc_i    (ld_pc),
    .instr_i (ld_instr),
    .valid_o (if_id_valid),
    .pc_o    (if_id_pc),
    .instr_o (if_id_instr)
  );
  assign opcode      = if_id_instr[6:0];
  assign funct3      = if_id_instr[14:12];
  assign funct7      = if_id_instr[31:25];
  assign fetch_count = fetch_count_q;
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: table-driven cycle checks plus a decode-side consumption scoreboard
module tb_instr_fetch;
  import riscv_pkg::*;
  logic        clk = 1'b0, rst_n = 1'b1, stall = 1'b0, redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        if_id_valid;
  logic [31:0] if_id_pc, if_id_instr, fetch_count;
  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;
  logic [1:0]  wcnt;
  int          lat = 0, n_chk = 0, n_fail = 0;
  logic [31:0] sbq[$];
  typedef struct {
    logic st, rd; logic [31:0] rpc;
    logic push;   logic [31:0] ppc;
    logic req;    logic [31:0] addr;
    logic v;      logic [31:0] pc;
    logic [31:0] cnt;
  } row_t;
  row_t rows[14];
  instr_fetch_if #(.XLEN(32)) bus();
  instr_fetch #(.XLEN(32), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .imem(bus), .if_id_valid(if_id_valid), .if_id_pc(if_id_pc), .if_id_instr(if_id_instr),
    .opcode(opcode), .funct3(funct3), .funct7(funct7), .fetch_count(fetch_count)
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a == 32'h0) ? 32'h00A00093 : ({a[29:0], 2'b11} ^ 32'hA500_0000);
  endfunction
  // memory answers after lat wait cycles; reset together with the fetch stage
  assign bus.valid = bus.req && (int'(wcnt) >= lat);
  assign bus.rdata = mem_word(bus.addr);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) wcnt <= 2'd0;
    else wcnt <= (bus.req && !bus.valid) ? wcnt + 2'd1 : 2'd0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic nxt();
    @(posedge clk);
    #1;
  endtask
  task automatic chk_reset();
    chk("rst_req", {31'd0, bus.req}, 0);
    chk("rst_valid", {31'd0, if_id_valid}, 0);
    chk("rst_pc", if_id_pc, 0);
    chk("rst_instr", if_id_instr, NOP);
    chk("rst_opcode", {25'd0, opcode}, {25'd0, 7'b0010011});
    chk("rst_cnt", fetch_count, 0);
  endtask
  always @(negedge clk)
    if (rst_n && if_id_valid && !stall && !redirect) begin
      if (sbq.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL sb_extra: got pc %h expected no delivery", if_id_pc);
      end else begin
        logic [31:0] e;
        e = sbq.pop_front();
        chk("sb_pc", if_id_pc, e);
        chk("sb_instr", if_id_instr, mem_word(e));
      end
    end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    row_t r;
    logic [31:0] ei;
    rows[0]  = '{0, 0, 32'h0,         0, 32'h0,         0, 32'h0,         0, 32'h0,         0};
    rows[1]  = '{0, 0, 32'h0,         0, 32'h0,         1, 32'h0,         0, 32'h0,         0};
    rows[2]  = '{0, 0, 32'h0,         1, 32'h0,         1, 32'h4,         1, 32'h0,         1};
    rows[3]  = '{1, 0, 32'h0,         0, 32'h0,         1, 32'h8,         1, 32'h4,         2};
    rows[4]  = '{1, 0, 32'h0,         0, 32'h0,         0, 32'h0,         1, 32'h4,         2};
    rows[5]  = '{1, 0, 32'h0,         0, 32'h0,         0, 32'h0,         1, 32'h4,         2};
    rows[6]  = '{0, 0, 32'h0,         1, 32'h4,         0, 32'h0,         1, 32'h4,         2};
    rows[7]  = '{0, 0, 32'h0,         1, 32'h8,         1, 32'hC,         1, 32'h8,         3};
    rows[8]  = '{1, 1, 32'h43,        0, 32'h0,         1, 32'h10,        1, 32'hC,         4};
    rows[9]  = '{0, 0, 32'h0,         0, 32'h0,         1, 32'h40,        0, 32'h0,         4};
    rows[10] = '{0, 1, 32'hFFFF_FFFE, 0, 32'h0,         1, 32'h44,        1, 32'h40,        5};
    rows[11] = '{0, 0, 32'h0,         0, 32'h0,         1, 32'hFFFF_FFFC, 0, 32'h0,         5};
    rows[12] = '{0, 0, 32'h0,         1, 32'hFFFF_FFFC, 1, 32'h0,         1, 32'hFFFF_FFFC, 6};
    rows[13] = '{0, 0, 32'h0,         1, 32'h0,         1, 32'h4,         1, 32'h0,         7};
    #1 rst_n = 1'b0;
    repeat (2) nxt();
    @(negedge clk);
    chk_reset();
    nxt();
    rst_n = 1'b1;
    for (int i = 0; i < 14; i++) begin
      r = rows[i];
      stall = r.st;
      redirect = r.rd;
      redirect_pc = r.rpc;
      if (r.push) sbq.push_back(r.ppc);
      @(negedge clk);
      ei = r.v ? mem_word(r.pc) : NOP;
      chk($sformatf("c%0d_req", i), {31'd0, bus.req}, {31'd0, r.req});
      if (r.req) chk($sformatf("c%0d_addr", i), bus.addr, r.addr);
      chk($sformatf("c%0d_valid", i), {31'd0, if_id_valid}, {31'd0, r.v});
      chk($sformatf("c%0d_pc", i), if_id_pc, r.pc);
      chk($sformatf("c%0d_instr", i), if_id_instr, ei);
      chk($sformatf("c%0d_opcode", i), {25'd0, opcode}, {25'd0, ei[6:0]});
      chk($sformatf("c%0d_funct3", i), {29'd0, funct3}, {29'd0, ei[14:12]});
      chk($sformatf("c%0d_funct7", i), {25'd0, funct7}, {25'd0, ei[31:25]});
      chk($sformatf("c%0d_cnt", i), fetch_count, r.cnt);
      nxt();
    end
    sbq.push_back(32'h4);
    dut.fetch_count_q = 32'hFFFF_FFFF;
    @(negedge clk);
    nxt();
    sbq.push_back(32'h8);
    @(negedge clk);
    chk("cnt_wrap", fetch_count, 0);
    chk("wrap_pc", if_id_pc, 32'h8);
    nxt();
    stall = 1'b1;
    @(negedge clk);
    chk("sb_drain1", sbq.size(), 0);
    lat = 2;
    nxt();
    rst_n = 1'b0;
    stall = 1'b0;
    repeat (2) nxt();
    sbq.delete();
    rst_n = 1'b1;
    @(negedge clk);
    chk("l_boot_req", {31'd0, bus.req}, 0);
    nxt();
    redirect = 1'b1;
    redirect_pc = 32'h10;
    @(negedge clk);
    chk("l_c1_addr", bus.addr, 32'h0);
    nxt();
    redirect = 1'b0;
    @(negedge clk);
    chk("l_c2_req", {31'd0, bus.req}, 1);
    chk("l_c2_addr", bus.addr, 32'h0);
    nxt();
    @(negedge clk);
    chk("l_c3_addr", bus.addr, 32'h0);
    nxt();
    @(negedge clk);
    chk("l_c4_addr", bus.addr, 32'h10);
    nxt();
    redirect = 1'b1;
    redirect_pc = 32'h103;
    @(negedge clk);
    chk("l_c5_addr", bus.addr, 32'h10);
    nxt();
    redirect = 1'b0;
    @(negedge clk);
    chk("l_c6_req", {31'd0, bus.req}, 1);
    chk("l_c6_addr", bus.addr, 32'h10);
    chk("l_c6_valid", {31'd0, if_id_valid}, 0);
    nxt();
    @(negedge clk);
    chk("l_c7_addr", bus.addr, 32'h100);
    chk("l_c7_valid", {31'd0, if_id_valid}, 0);
    nxt();
    @(negedge clk);
    chk("l_c8_valid", {31'd0, if_id_valid}, 0);
    nxt();
    @(negedge clk);
    chk("l_c9_valid", {31'd0, if_id_valid}, 0);
    nxt();
    sbq.push_back(32'h100);
    @(negedge clk);
    chk("l_c10_valid", {31'd0, if_id_valid}, 1);
    chk("l_c10_pc", if_id_pc, 32'h100);
    chk("l_c10_addr", bus.addr, 32'h104);
    chk("l_c10_cnt", fetch_count, 1);
    nxt();
    redirect = 1'b1;
    redirect_pc = 32'h200;
    @(negedge clk);
    chk("l_c11_bubble", {31'd0, if_id_valid}, 0);
    chk("l_c11_addr", bus.addr, 32'h104);
    nxt();
    redirect = 1'b0;
    chk("kill_req", {31'd0, bus.req}, 1);
    chk("kill_addr", bus.addr, 32'h104);
    rst_n = 1'b0;
    @(negedge clk);
    chk_reset();
    chk("sb_drain2", sbq.size(), 0);
    nxt();
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_c0_req", {31'd0, bus.req}, 0);
    nxt();
    @(negedge clk);
    chk("rel_c1_req", {31'd0, bus.req}, 1);
    chk("rel_c1_addr", bus.addr, 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage with IF/ID pipeline register, directly upstream of the decode/control stage. Holds the PC, issues word requests to instruction memory over a request/valid handshake, and latches each returned instruction with its PC into the IF/ID register. Presents the slices `opcode`, `funct3` and `funct7` to the control unit. Handles decode-side stalls with a one-entry hold buffer and branch redirects from execute with a kill of any in-flight fetch.

## Interface
Parameters:
- `XLEN`, 32: PC and instruction width.
- `RESET_PC`, 32'h0000_0000: first fetch address after reset.

Ports:
- `clk`, in, 1: single clock; all state on rising edge.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `stall`, in, 1: decode cannot accept; IF/ID must hold.
- `redirect`, in, 1: taken branch from execute.
- `redirect_pc`, in, XLEN: branch target; bits [1:0] forced to 0.
- `imem_req`, out, 1: fetch request.
- `imem_addr`, out, XLEN: fetch address; stable while `imem_req`=1 until `imem_valid`.
- `imem_valid`, in, 1: response strobe; may assert in the same cycle as `imem_req`.
- `imem_rdata`, in, 32: instruction, qualified by `imem_valid`.
- `if_id_valid`, out, 1: IF/ID holds a live instruction.
- `if_id_pc`, out, XLEN: PC of the IF/ID instruction.
- `if_id_instr`, out, 32: IF/ID instruction.
- `opcode`, out, 7: `if_id_instr[6:0]`.
- `funct3`, out, 3: `if_id_instr[14:12]`.
- `funct7`, out, 7: `if_id_instr[31:25]`.
- `fetch_count`, out, 32: count of instructions delivered into IF/ID; wraps at 2^32.

## Operation
- Reset values:
  - `pc`=`RESET_PC`.
  - State `S_BOOT`; `imem_req`=0.
  - `if_id_valid`=0, `if_id_pc`=0, `if_id_instr`=32'h0000_0013 (ADDI x0,x0,0, the NOP).
  - `fetch_count`=0; hold buffer empty.
- `if_id_instr` resets and flushes to NOP, never 0, so decode sees a legal I-type.
- Field outputs are purely combinational slices of `if_id_instr`.
- FSM states: `S_BOOT`, `S_REQ`, `S_KILL`, `S_HOLD`.
- `S_BOOT`: `imem_req`=0. Go to `S_REQ` unconditionally next cycle.
- `S_REQ`: `imem_req`=1, `imem_addr`=`pc`.
  - `imem_valid` & `redirect`: discard data; `pc`<=`redirect_pc`; stay `S_REQ`.
  - `redirect` without `imem_valid`: `pc`<=`redirect_pc`; hold `imem_addr` at the old value; go `S_KILL`.
  - `imem_valid` & !`stall`: IF/ID<={1, `pc`, `imem_rdata`}; `pc`<=`pc`+4; `fetch_count`++; stay `S_REQ`.
  - `imem_valid` & `stall`: hold buffer<={`pc`, `imem_rdata`}; `pc`<=`pc`+4; go `S_HOLD`.
- `S_KILL`: `imem_req`=1 with the old address; wait for `imem_valid`, drop its data, return to `S_REQ`. A further `redirect` here updates `pc` only.
- `S_HOLD`: `imem_req`=0.
  - `redirect`: drop buffer; `pc`<=`redirect_pc`; go `S_REQ`.
  - !`stall`: IF/ID<=buffer; `fetch_count`++; go `S_REQ`.
- IF/ID rules:
  - `redirect` (any state): IF/ID<={0, 0, NOP}. Flush overrides `stall`.
  - `stall` & !`redirect`: IF/ID holds every field.
- Arithmetic: `pc`+4 wraps modulo 2^XLEN; `fetch_count` wraps 0xFFFF_FFFF -> 0.
- Reset mid-fetch: all state returns to reset values immediately. The outstanding response is not tracked; the memory must also be reset by `rst_n`.

## Timing
- Zero-wait memory (`imem_valid` same cycle as `imem_req`): one instruction per cycle. IF/ID is updated at the edge ending the request cycle.
- Fetch latency: first IF/ID valid is 2 cycles after reset release (`S_BOOT`, then `S_REQ`), for zero-wait memory.
- Redirect penalty:
  - Zero-wait memory: target is requested in the cycle after `redirect`.
  - N-cycle memory: one full extra response time, spent in `S_KILL`.
- `imem_addr` and `imem_req` come from registers, with no combinational path from `stall` or `redirect`.
- No instruction is lost or duplicated across any stall/redirect interleaving.

## Structure
- Shared package `riscv_pkg` holds:
  - `XLEN` default.
  - NOP constant 32'h0000_0013.
  - Opcode constants (0110011, 0010011, 1100011, 0000011, 0100011), shared with the control unit.
  - FSM state enum.
- One sub-module `if_id_reg`: the valid/pc/instr register with load, hold (`stall`) and flush (`redirect`). The FSM, PC and hold buffer live in `instr_fetch`.

## Test plan
- Reset release, zero-wait memory returning 32'h00A00093 at 0x0 -> `imem_addr` 0x0 on cycle 1; `if_id_valid`=1, `opcode`=7'b0010011, `funct3`=0 on cycle 2; next `imem_addr`=0x4.
- `stall`=1 for 3 cycles while the fetch at 0x8 completes -> IF/ID holds; `imem_req`=0 in `S_HOLD`; on release IF/ID gets `pc` 0x8; `fetch_count` increments exactly once for it.
- 3-cycle-latency memory, `redirect`=1 with `redirect_pc`=0x103 one cycle after the request to 0x10 -> `imem_addr` stays 0x10 until `imem_valid`; data dropped; next request to 0x100; `if_id_valid`=0 meanwhile.
- `redirect` and `imem_valid` in the same cycle, with `stall`=1 -> IF/ID flushed to NOP/valid 0 despite stall; next `imem_addr`=`redirect_pc`.
- `pc`=0xFFFF_FFFC, zero-wait -> next `imem_addr`=0x0. Preload `fetch_count` to 0xFFFF_FFFF -> one delivery gives 0.
- Assert `rst_n`=0 mid-`S_KILL` -> all outputs at reset values that cycle; `imem_addr`=`RESET_PC` after release.
